// File: rtl/pipeline_pkg.sv
// Shared definitions for the EX-stage hazard controller.
// Holds the operand-mux select encodings, the shadow-pipeline slot layout
// and the multicycle FSM state encoding.
package pipeline_pkg;

    // EX operand mux selects (2'b11 is never driven)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Multicycle countdown width; covers MC_CYCLES-1 up to 15
    localparam int CNT_W = 5;

    // One shadow-pipeline slot: just enough of an instruction to resolve hazards
    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
    } shadow_slot_t;

    localparam shadow_slot_t SLOT_BUBBLE = '0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/forward_select.sv
// Forwarding select for one EX operand.
// Ports:
//   ex_valid, ex_src, ex_uses       - EX-slot instruction and the operand it reads
//   mem_valid, mem_regwrite, mem_dest - producer currently in MEM
//   wb_valid, wb_regwrite, wb_dest    - producer currently in WB
//   fwd_sel                          - FWD_MEM / FWD_WB / FWD_REG
module forward_select
    import pipeline_pkg::*;
(
    input  logic       ex_valid,
    input  logic [4:0] ex_src,
    input  logic       ex_uses,
    input  logic       mem_valid,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_dest,
    input  logic       wb_valid,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_dest,
    output logic [1:0] fwd_sel
);

    logic need;
    logic mem_hit;
    logic wb_hit;

    // A bubble in EX, or an operand that is not read, never forwards
    assign need    = ex_valid & ex_uses;
    // $0 is hard-wired zero, so a write to it is never a real producer
    assign mem_hit = need & mem_valid & mem_regwrite & (mem_dest != 5'd0) & (mem_dest == ex_src);
    assign wb_hit  = need & wb_valid  & wb_regwrite  & (wb_dest  != 5'd0) & (wb_dest  == ex_src);

    // MEM holds the younger value, so it wins over WB
    always_comb begin
        fwd_sel = FWD_REG;
        if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// EX-stage hazard controller: forwarding selects, load-use interlock and
// multicycle-op occupancy of EX, driven from a shadow copy of EX/MEM/WB.
// Ports:
//   clk, rst_n                          - clock, asynchronous active-low reset
//   id_valid, id_rs/rt/rd, id_uses_rs/rt - ID instruction and its operands
//   id_regdst, id_regwrite, id_memread, id_multicycle - ID control bits
//   flush                               - squash the ID instruction
//   ForwardA, ForwardB                  - EX operand mux selects
//   stall                               - hold PC and IF/ID
//   ex_bubble                           - load zero control into ID/EX
//   ex_hold                             - keep ID/EX contents (multicycle in EX)
module ex_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MC_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_regdst,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       id_multicycle,
    input  logic       flush,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       stall,
    output logic       ex_bubble,
    output logic       ex_hold
);

    shadow_slot_t     id_slot;
    shadow_slot_t     slot_ex_p0;
    shadow_slot_t     slot_mem_p1;
    shadow_slot_t     slot_wb_p2;
    mc_state_t        state;
    mc_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             squash_id;
    logic             eff_flush;
    logic             mc_hold;
    logic             load_use;
    logic             ex_load;

    always_comb begin
        id_slot          = SLOT_BUBBLE;
        id_slot.valid    = 1'b1;
        id_slot.rs       = id_rs;
        id_slot.rt       = id_rt;
        id_slot.uses_rs  = id_uses_rs;
        id_slot.uses_rt  = id_uses_rt;
        id_slot.dest     = id_regdst ? id_rd : id_rt;
        id_slot.regwrite = id_regwrite;
        id_slot.memread  = id_memread;
    end

    // The last EX cycle of a multicycle op (cnt==0) no longer holds
    assign mc_hold = (state == ST_MC_BUSY) && (cnt != '0);

    // A flush seen while EX is held must still kill that ID instruction
    // when the hold releases, since IF/ID was frozen under it
    assign eff_flush = flush | squash_id;

    assign load_use = slot_ex_p0.valid & slot_ex_p0.memread & slot_ex_p0.regwrite &
                      (slot_ex_p0.dest != 5'd0) & id_valid &
                      ((id_uses_rs & (id_rs == slot_ex_p0.dest)) |
                       (id_uses_rt & (id_rt == slot_ex_p0.dest)));

    assign stall     = mc_hold | (load_use & ~eff_flush);
    assign ex_bubble = ~mc_hold & (eff_flush | load_use);
    assign ex_hold   = mc_hold;
    assign ex_load   = id_valid & ~stall & ~eff_flush;

    // ---- ID -> EX -> MEM -> WB shadow pipeline ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_ex_p0  <= SLOT_BUBBLE;
            slot_mem_p1 <= SLOT_BUBBLE;
            slot_wb_p2  <= SLOT_BUBBLE;
        end else begin
            slot_wb_p2  <= slot_mem_p1;
            slot_mem_p1 <= mc_hold ? SLOT_BUBBLE : slot_ex_p0;
            if (!mc_hold) begin
                slot_ex_p0 <= ex_load ? id_slot : SLOT_BUBBLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_id <= 1'b0;
        end else begin
            squash_id <= mc_hold & (squash_id | flush);
        end
    end

    // ---- multicycle FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        // Reload first so back-to-back multicycle ops run without a gap
        if (ex_load && id_multicycle) begin
            state_nxt = ST_MC_BUSY;
            cnt_nxt   = CNT_W'(MC_CYCLES - 1);
        end else if (state == ST_MC_BUSY) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // ---- EX -> operand forwarding ----
    forward_select u_fwd_a (
        .ex_valid     (slot_ex_p0.valid),
        .ex_src       (slot_ex_p0.rs),
        .ex_uses      (slot_ex_p0.uses_rs),
        .mem_valid    (slot_mem_p1.valid),
        .mem_regwrite (slot_mem_p1.regwrite),
        .mem_dest     (slot_mem_p1.dest),
        .wb_valid     (slot_wb_p2.valid),
        .wb_regwrite  (slot_wb_p2.regwrite),
        .wb_dest      (slot_wb_p2.dest),
        .fwd_sel      (ForwardA)
    );

    forward_select u_fwd_b (
        .ex_valid     (slot_ex_p0.valid),
        .ex_src       (slot_ex_p0.rt),
        .ex_uses      (slot_ex_p0.uses_rt),
        .mem_valid    (slot_mem_p1.valid),
        .mem_regwrite (slot_mem_p1.regwrite),
        .mem_dest     (slot_mem_p1.dest),
        .wb_valid     (slot_wb_p2.valid),
        .wb_regwrite  (slot_wb_p2.regwrite),
        .wb_dest      (slot_wb_p2.dest),
        .fwd_sel      (ForwardB)
    );

endmodule

// File: tb/tb_ex_hazard_controller.sv
module tb_ex_hazard_controller;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_regdst;
    logic       id_regwrite;
    logic       id_memread;
    logic       id_multicycle;
    logic       flush;
    logic [1:0] ForwardA;
    logic [1:0] ForwardB;
    logic       stall;
    logic       ex_bubble;
    logic       ex_hold;

    int n_total = 0;
    int n_pass  = 0;

    ex_hazard_controller #(.MC_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_regdst     (id_regdst),
        .id_regwrite   (id_regwrite),
        .id_memread    (id_memread),
        .id_multicycle (id_multicycle),
        .flush         (flush),
        .ForwardA      (ForwardA),
        .ForwardB      (ForwardB),
        .stall         (stall),
        .ex_bubble     (ex_bubble),
        .ex_hold       (ex_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic rdst, input logic rw, input logic mr,
                          input logic mc, input logic fl);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_rd         = rd;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_regdst     = rdst;
        id_regwrite   = rw;
        id_memread    = mr;
        id_multicycle = mc;
        flush         = fl;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_id(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] base, input logic [4:0] rt);
        set_id(1'b1, base, rt, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mc_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_id(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        @(posedge clk);
        @(posedge clk);
        #1;
        // during reset
        chk("rst_fa", {2'b0, ForwardA}, 4'h0);
        chk("rst_fb", {2'b0, ForwardB}, 4'h0);
        chk("rst_stall", {3'b0, stall}, 4'h0);
        chk("rst_bubble", {3'b0, ex_bubble}, 4'h0);
        chk("rst_hold", {3'b0, ex_hold}, 4'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_stall", {3'b0, stall}, 4'h0);

        // add $3,$1,$2 ; sub $4,$3,$5
        drain();
        r_type(5'd1, 5'd2, 5'd3);
        step();
        r_type(5'd3, 5'd5, 5'd4);
        chk("alu_no_stall", {3'b0, stall}, 4'h0);
        step();
        nop();
        chk("mem_fwd_a", {2'b0, ForwardA}, 4'h2);
        chk("mem_fwd_b", {2'b0, ForwardB}, 4'h0);

        // add $3 ; nop ; or $6,$7,$3
        drain();
        r_type(5'd1, 5'd2, 5'd3);
        step();
        nop();
        step();
        r_type(5'd7, 5'd3, 5'd6);
        step();
        nop();
        chk("wb_fwd_b", {2'b0, ForwardB}, 4'h1);
        chk("wb_fwd_a", {2'b0, ForwardA}, 4'h0);

        // producer writes $0
        drain();
        r_type(5'd1, 5'd2, 5'd0);
        step();
        r_type(5'd0, 5'd5, 5'd4);
        step();
        nop();
        chk("r0_fwd_a", {2'b0, ForwardA}, 4'h0);
        chk("r0_fwd_b", {2'b0, ForwardB}, 4'h0);

        // MEM wins over WB for the same register
        drain();
        r_type(5'd1, 5'd2, 5'd3);
        step();
        r_type(5'd1, 5'd2, 5'd3);
        step();
        r_type(5'd3, 5'd3, 5'd6);
        step();
        nop();
        chk("prio_fwd_a", {2'b0, ForwardA}, 4'h2);
        chk("prio_fwd_b", {2'b0, ForwardB}, 4'h2);

        // lw $8,0($9) ; add $10,$8,$8
        drain();
        lw(5'd9, 5'd8);
        step();
        r_type(5'd8, 5'd8, 5'd10);
        chk("lu_stall", {3'b0, stall}, 4'h1);
        chk("lu_bubble", {3'b0, ex_bubble}, 4'h1);
        step();
        chk("lu_stall_once", {3'b0, stall}, 4'h0);
        chk("lu_bubble_once", {3'b0, ex_bubble}, 4'h0);
        step();
        nop();
        chk("lu_fwd_a", {2'b0, ForwardA}, 4'h1);
        chk("lu_fwd_b", {2'b0, ForwardB}, 4'h1);

        // load-use with flush
        drain();
        lw(5'd9, 5'd8);
        step();
        set_id(1'b1, 5'd8, 5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fl_stall", {3'b0, stall}, 4'h0);
        chk("fl_bubble", {3'b0, ex_bubble}, 4'h1);
        step();
        nop();
        chk("fl_fwd_a", {2'b0, ForwardA}, 4'h0);
        chk("fl_fwd_b", {2'b0, ForwardB}, 4'h0);

        // multicycle $11,$11,$1 then dependent add $12,$11,$1
        drain();
        mc_op(5'd11, 5'd1, 5'd11);
        step();
        r_type(5'd11, 5'd1, 5'd12);
        chk("mc_c1_stall", {3'b0, stall}, 4'h1);
        chk("mc_c1_hold", {3'b0, ex_hold}, 4'h1);
        chk("mc_c1_bubble", {3'b0, ex_bubble}, 4'h0);
        chk("mc_c1_fwd_a", {2'b0, ForwardA}, 4'h0);
        step();
        chk("mc_c2_hold", {3'b0, ex_hold}, 4'h1);
        chk("mc_c2_mem_bubble", {2'b0, ForwardA}, 4'h0);
        step();
        chk("mc_c3_hold", {3'b0, ex_hold}, 4'h1);
        chk("mc_c3_stall", {3'b0, stall}, 4'h1);
        step();
        chk("mc_c4_hold", {3'b0, ex_hold}, 4'h0);
        chk("mc_c4_stall", {3'b0, stall}, 4'h0);
        chk("mc_c4_bubble", {3'b0, ex_bubble}, 4'h0);
        step();
        nop();
        chk("mc_dep_fwd_a", {2'b0, ForwardA}, 4'h2);
        chk("mc_dep_fwd_b", {2'b0, ForwardB}, 4'h0);
        chk("mc_idle_hold", {3'b0, ex_hold}, 4'h0);

        // back-to-back multicycle ops
        drain();
        mc_op(5'd1, 5'd2, 5'd13);
        step();
        mc_op(5'd4, 5'd5, 5'd14);
        chk("b2b_a_c1", {3'b0, ex_hold}, 4'h1);
        step();
        chk("b2b_a_c2", {3'b0, ex_hold}, 4'h1);
        step();
        chk("b2b_a_c3", {3'b0, ex_hold}, 4'h1);
        step();
        chk("b2b_a_c4", {3'b0, ex_hold}, 4'h0);
        step();
        nop();
        chk("b2b_b_c1", {3'b0, ex_hold}, 4'h1);
        step();
        chk("b2b_b_c2", {3'b0, ex_hold}, 4'h1);
        step();
        chk("b2b_b_c3", {3'b0, ex_hold}, 4'h1);
        step();
        chk("b2b_b_c4", {3'b0, ex_hold}, 4'h0);

        // flush while a multicycle op is busy
        drain();
        mc_op(5'd1, 5'd2, 5'd11);
        step();
        set_id(1'b1, 5'd11, 5'd1, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("mcfl_stall", {3'b0, stall}, 4'h1);
        chk("mcfl_bubble", {3'b0, ex_bubble}, 4'h0);
        step();
        r_type(5'd11, 5'd1, 5'd12);
        chk("mcfl_not_aborted", {3'b0, ex_hold}, 4'h1);
        step();
        step();
        chk("mcfl_last_bubble", {3'b0, ex_bubble}, 4'h1);
        chk("mcfl_last_stall", {3'b0, stall}, 4'h0);
        step();
        nop();
        chk("mcfl_squashed_fa", {2'b0, ForwardA}, 4'h0);
        chk("mcfl_squashed_fb", {2'b0, ForwardB}, 4'h0);

        // reset pulse in the second busy cycle
        drain();
        mc_op(5'd1, 5'd2, 5'd11);
        step();
        step();
        nop();
        chk("mrst_pre_hold", {3'b0, ex_hold}, 4'h1);
        rst_n = 1'b0;
        #1;
        chk("mrst_async_hold", {3'b0, ex_hold}, 4'h0);
        chk("mrst_async_stall", {3'b0, stall}, 4'h0);
        #1;
        rst_n = 1'b1;
        step();
        chk("mrst_hold", {3'b0, ex_hold}, 4'h0);
        chk("mrst_stall", {3'b0, stall}, 4'h0);
        chk("mrst_bubble", {3'b0, ex_bubble}, 4'h0);
        chk("mrst_fa", {2'b0, ForwardA}, 4'h0);
        chk("mrst_fb", {2'b0, ForwardB}, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_hazard_controller.md
EX_HAZARD_CONTROLLER -- requirements
Module: ex_hazard_controller

Interface
REQ-001 SHALL have parameter MC_CYCLES, default 4, meaning EX-stage occupancy in cycles of a multicycle op (legal 2..16).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port id_valid  in  1  ID stage holds a real instruction.
REQ-005 SHALL have ports id_rs, id_rt, id_rd  in  5 each  ID source/target/dest register fields.
REQ-006 SHALL have ports id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs/rt.
REQ-007 SHALL have ports id_regdst, id_regwrite, id_memread, id_multicycle  in  1 each  ID control bits.
REQ-008 SHALL have port flush  in  1  squash the ID instruction (taken branch/jump).
REQ-009 SHALL have ports ForwardA, ForwardB  out  2 each  EX operand mux selects: 00 register file, 01 WB result, 10 EX/MEM result, 11 never driven.
REQ-010 SHALL have port stall  out  1  hold PC and IF/ID register.
REQ-011 SHALL have port ex_bubble  out  1  load all-zero control into ID/EX.
REQ-012 SHALL have port ex_hold  out  1  hold ID/EX contents (multicycle op in EX).

Function
REQ-013 SHALL keep a shadow pipeline of three slots EX, MEM, WB, each holding valid, rs, rt, uses_rs, uses_rt, dest, regwrite, memread.
REQ-014 SHALL compute dest on ID->EX entry as id_rd when id_regdst=1 else id_rt.
REQ-015 SHALL advance every cycle: WB<=MEM; MEM<=EX unless ex_hold (then MEM<=bubble); EX<=ID when id_valid & !stall & !flush, EX<=bubble when ex_bubble or flush, EX unchanged when ex_hold.
REQ-016 SHALL drive ForwardA combinationally from EX slot: 10 if MEM.valid & MEM.regwrite & MEM.dest!=0 & MEM.dest==EX.rs & EX.uses_rs; else 01 if same test against WB; else 00.
REQ-017 SHALL drive ForwardB identically using EX.rt/EX.uses_rt.
REQ-018 SHALL give MEM priority over WB when both match the same register.
REQ-019 SHALL never forward register 0; ForwardA/B SHALL be 00 while EX slot is a bubble.
REQ-020 SHALL detect load-use: EX.valid & EX.memread & EX.regwrite & EX.dest!=0 & id_valid & ((id_uses_rs & id_rs==EX.dest) | (id_uses_rt & id_rt==EX.dest)); then stall=1 and ex_bubble=1 for exactly one cycle.
REQ-021 SHALL run FSM IDLE/MC_BUSY: IDLE->MC_BUSY when an instruction with id_multicycle enters EX, loading counter with MC_CYCLES-1; in MC_BUSY counter decrements each cycle; MC_BUSY->IDLE when counter reaches 0 (that cycle is the op's last EX cycle).
REQ-022 SHALL assert stall and ex_hold in MC_BUSY while counter!=0; ex_bubble=0 in MC_BUSY.
REQ-023 ForwardA/B SHALL be valid on the first EX cycle of a multicycle op; datapath latches operands then.
REQ-024 flush SHALL override load-use: flush=1 forces stall=0 from load-use, ex_bubble=1.
REQ-025 flush SHALL NOT abort a multicycle op already in EX; during MC_BUSY flush squashes only the ID instruction (recorded so it never enters EX).
REQ-026 Back-to-back multicycle ops SHALL each take MC_CYCLES EX cycles with no idle gap.

Reset
REQ-027 On rst_n=0 all shadow slots SHALL be invalid, FSM IDLE, counter 0, asynchronously.
REQ-028 During and after reset, ForwardA=ForwardB=00, stall=0, ex_bubble=0, ex_hold=0 until id_valid inputs change them.
REQ-029 Reset mid multicycle op SHALL return to IDLE immediately; no residual stall.

Structure
REQ-030 Shared package pipeline_pkg SHALL hold forward encodings FWD_REG/FWD_WB/FWD_MEM, the shadow-slot typedef and FSM state enum.
REQ-031 Per-operand match logic SHALL be one sub-module forward_select, instantiated twice (A, B).
REQ-032 Implementation SHALL be 120-400 lines RTL, no latches, no combinational loops.

Verification
REQ-033 add $3,$1,$2 then sub $4,$3,$5 -> second in EX: ForwardA=10, ForwardB=00.
REQ-034 add $3; nop; or $6,$7,$3 -> or in EX: ForwardB=01; add $0 producer -> Forward=00.
REQ-035 lw $8,0($9) then add $10,$8,$8 -> one cycle stall=1, ex_bubble=1; next cycle ForwardA=ForwardB=01.
REQ-036 multicycle op, MC_CYCLES=4 -> stall=ex_hold=1 for 3 cycles, MEM receives 3 bubbles, FSM IDLE after.
REQ-037 load-use coincident with flush=1 -> stall=0, ex_bubble=1; rst_n pulse during MC_BUSY cycle 2 -> all outputs 0 next edge.
